// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: fetch widths, queue depth, instruction
// field slices and the fetch-stage state encoding.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int INS_W  = 16;
    localparam int DEPTH  = 4;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 9;
    localparam int FLD_HI = 8;
    localparam int FLD_LO = 0;

    localparam logic [INS_W-1:0] NOP = 16'h0000;

    typedef enum logic {
        S_RESET = 1'b0,
        S_RUN   = 1'b1
    } ifq_state_e;

    function automatic logic [OPC_HI-OPC_LO:0] ins_opcode(
        input logic [INS_W-1:0] w
    );
        return w[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [FLD_HI-FLD_LO:0] ins_fields(
        input logic [INS_W-1:0] w
    );
        return w[FLD_HI:FLD_LO];
    endfunction

endpackage

// File: rtl/ins_fetch_queue_if.sv
// Fetch-stage bus: instruction memory read port, redirect input and the
// valid/ready hand-off to decode.
//   master : fetch stage (drives imem_req/addr, ins_valid/ins/ins_pc)
//   slave  : memory + decode + branch unit side
interface ins_fetch_queue_if
    import cpu_pkg::*;
;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [INS_W-1:0]  imem_rdata;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;
    logic              ins_valid;
    logic [INS_W-1:0]  ins;
    logic [ADDR_W-1:0] ins_pc;
    logic              ins_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redir_valid, redir_pc,
        output ins_valid, ins, ins_pc,
        input  ins_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redir_valid, redir_pc,
        input  ins_valid, ins, ins_pc,
        output ins_ready
    );

endinterface

// File: rtl/ins_fetch_queue_fifo.sv
// Small synchronous FIFO with a registered head word and occupancy count.
// Ports: clk, rst (sync, active-low), flush, wr_en/wr_data, rd_en, head, count.
module ifq_fifo
    import cpu_pkg::*;
#(
    parameter int W                = INS_W + ADDR_W,
    parameter int N                = DEPTH,
    parameter logic [W-1:0] INIT   = '0,
    localparam int CW              = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(N);

    logic [W-1:0]  mem [N];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_n;
    logic [CW-1:0] cnt_left;
    logic          do_rd;

    assign do_rd    = rd_en && (count != '0);
    assign rd_ptr_n = rd_ptr + PW'(do_rd);
    assign cnt_left = count - CW'(do_rd);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= INIT;
        end else begin
            assert (!(wr_en && count == CW'(N)));
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr_n;
            count  <= cnt_left + CW'(wr_en);
            // Head is the next entry after this cycle's pop; when that
            // leaves the queue empty, an incoming word bypasses to head.
            if (cnt_left == '0) begin
                if (wr_en) begin
                    head <= wr_data;
                end
            end else begin
                head <= mem[rd_ptr_n];
            end
        end
    end

endmodule

// File: rtl/ins_fetch_queue.sv
// Instruction fetch stage: owns the PC, issues reads to a 1-cycle
// instruction memory, queues returned words and hands them to decode.
// Ports: clk, rst (sync, active-low), bus (ins_fetch_queue_if.master).
module ins_fetch_queue
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ins_fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = INS_W + ADDR_W;

    ifq_state_e        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ret_addr;
    logic              inflight;
    logic              drop;
    logic              issue;
    logic              push;
    logic              pop;
    logic [CW-1:0]     count;
    logic [CW:0]       used;
    logic [FW-1:0]     head;

    // Credit counts queued words plus the read still in flight, so a
    // returning word always finds a free slot.
    assign used  = {1'b0, count} + (CW+1)'(inflight);
    assign issue = rst && !bus.redir_valid
                && (used < (CW+1)'(DEPTH));
    assign push  = inflight && !drop;
    assign pop   = bus.ins_valid && bus.ins_ready;

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc;
    assign bus.ins_valid = (count != '0);
    assign bus.ins       = head[FW-1:ADDR_W];
    assign bus.ins_pc    = head[ADDR_W-1:0];

    ifq_fifo #(
        .W    (FW),
        .N    (DEPTH),
        .INIT ({NOP, ADDR_W'(0)})
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.redir_valid),
        .wr_en   (push),
        .wr_data ({bus.imem_rdata, ret_addr}),
        .rd_en   (pop),
        .head    (head),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_RESET;
            pc       <= '0;
            ret_addr <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else begin
            unique case (state)
                S_RESET: begin
                    assert (!inflight);
                    state <= S_RUN;
                end
                S_RUN: state <= S_RUN;
            endcase
            if (bus.redir_valid) begin
                pc       <= bus.redir_pc;
                inflight <= 1'b0;
                drop     <= inflight;
            end else begin
                inflight <= issue;
                drop     <= 1'b0;
                if (issue) begin
                    pc       <= pc + ADDR_W'(1);
                    ret_addr <= pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Bench for ins_fetch_queue: directed scenarios then random ready/redirect
// traffic against an in-order program-stream reference model.
module tb_ins_fetch_queue;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ins_fetch_queue_if bif ();

    ins_fetch_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    logic [INS_W-1:0]  mem [2**ADDR_W];
    logic [ADDR_W-1:0] exp_pc;
    logic [ADDR_W-1:0] wrap_seq [4];
    int checks = 0;
    int errors = 0;
    int ntx    = 0;

    always @(posedge clk) begin
        if (bif.imem_req) bif.imem_rdata <= mem[bif.imem_addr];
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle, entered and left at a negedge. A transfer in this cycle
    // must deliver the next word of the current program stream.
    task automatic step(input logic rdy,
                        input logic rv,
                        input logic [ADDR_W-1:0] rp);
        bif.ins_ready   = rdy;
        bif.redir_valid = rv;
        bif.redir_pc    = rp;
        #1;
        if (bif.ins_valid === 1'b1 && rdy) begin
            chk("xfer_pc", 32'(bif.ins_pc), 32'(exp_pc));
            chk("xfer_ins", 32'(bif.ins), 32'(mem[exp_pc]));
            exp_pc = exp_pc + 1'b1;
            ntx++;
        end
        if (rv) exp_pc = rp;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = INS_W'(16'h1000 + i);
        wrap_seq[0] = 8'hFE;
        wrap_seq[1] = 8'hFF;
        wrap_seq[2] = 8'h00;
        wrap_seq[3] = 8'h01;
        exp_pc = '0;
        rst = 1'b0;
        bif.ins_ready   = 1'b0;
        bif.redir_valid = 1'b0;
        bif.redir_pc    = '0;

        // Reset held three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(bif.imem_req), 32'd0);
        chk("rst_valid", 32'(bif.ins_valid), 32'd0);
        chk("rst_ins", 32'(bif.ins), 32'd0);
        chk("rst_pc", 32'(bif.ins_pc), 32'd0);
        chk("rst_addr", 32'(bif.imem_addr), 32'd0);

        // Release: first issue now, word visible two cycles later
        rst = 1'b1;
        bif.ins_ready = 1'b1;
        #1;
        chk("rel_req", 32'(bif.imem_req), 32'd1);
        chk("rel_addr", 32'(bif.imem_addr), 32'd0);
        chk("lat_n0", 32'(bif.ins_valid), 32'd0);
        @(negedge clk);
        chk("lat_n1", 32'(bif.ins_valid), 32'd0);
        @(negedge clk);
        chk("lat_n2", 32'(bif.ins_valid), 32'd1);
        chk("lat_pc", 32'(bif.ins_pc), 32'd0);

        // Steady stream, one word per cycle
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", 32'(bif.ins_valid), 32'd1);
            step(1'b1, 1'b0, '0);
        end

        // Backpressure from a fresh start at 0
        step(1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, '0);
            if (k >= 5) begin
                chk("bp_req", 32'(bif.imem_req), 32'd0);
                chk("bp_count", 32'(dut.count), 32'd4);
                chk("bp_pc", 32'(bif.ins_pc), 32'd0);
                chk("bp_ins", 32'(bif.ins), 32'(mem[0]));
            end
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
        chk("bp_drain", 32'(exp_pc), 32'd6);

        // Redirect while the read of pc=5 is in flight
        step(1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
        chk("fl_req", 32'(bif.imem_req), 32'd1);
        chk("fl_addr", 32'(bif.imem_addr), 32'd5);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 8'h40);
        chk("fl_empty0", 32'(bif.ins_valid), 32'd0);
        step(1'b1, 1'b0, '0);
        chk("fl_empty1", 32'(bif.ins_valid), 32'd0);
        step(1'b1, 1'b0, '0);
        chk("fl_valid", 32'(bif.ins_valid), 32'd1);
        chk("fl_pc", 32'(bif.ins_pc), 32'h40);

        // Address wrap
        step(1'b1, 1'b1, 8'hFE);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_pc", 32'(bif.ins_pc), 32'(wrap_seq[i]));
            step(1'b1, 1'b0, '0);
        end

        // Back-to-back redirects: only the last target is fetched
        step(1'b1, 1'b1, 8'h10);
        step(1'b1, 1'b1, 8'h20);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        chk("b2b_pc", 32'(bif.ins_pc), 32'h20);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);

        // Reset and redirect in the same cycle: reset wins
        bif.ins_ready   = 1'b0;
        bif.redir_valid = 1'b1;
        bif.redir_pc    = 8'h80;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_req", 32'(bif.imem_req), 32'd0);
        chk("mr_valid", 32'(bif.ins_valid), 32'd0);
        chk("mr_ins", 32'(bif.ins), 32'd0);
        chk("mr_pc", 32'(bif.ins_pc), 32'd0);
        bif.redir_valid = 1'b0;
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = INS_W'($urandom);
        @(negedge clk);
        rst = 1'b1;
        exp_pc = '0;
        #1;
        chk("mr_addr", 32'(bif.imem_addr), 32'd0);
        chk("mr_issue", 32'(bif.imem_req), 32'd1);
        @(negedge clk);
        chk("mr_nostale", 32'(bif.ins_valid), 32'd0);

        // Random ready and redirect traffic
        ntx = 0;
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0,
                 ADDR_W'($urandom));
        end
        chk("rand_progress", 32'(ntx > 150), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
